wb_csr_bridge: RTL and testbench
================================

# wb_csr_bridge

Wishbone-classic slave to CSR-master bridge that sits directly upstream of the CSR SRAM controller and feeds its CSR slave port. It converts each 16-bit Wishbone cycle into a single one-cycle CSR issue, waits a fixed read latency, captures the returned data, and terminates the Wishbone cycle with a one-cycle ack. There is one transaction in flight at a time and no buffering.

## Interface
- READ_LAT, 2, cycles from the CSR issue cycle to the cycle in which csr_dat_i is valid; legal range 1..7.

Ports (clock and reset first):
- sys_clk  in  1  single clock for the whole block.
- sys_rst_n  in  1  reset, asynchronous assertion, active-low.
- wb_adr_i  in  17  word address [17:1].
- wb_sel_i  in  2  byte lane selects.
- wb_we_i  in  1  write enable.
- wb_dat_i  in  16  write data.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  16  read data; valid when wb_ack_o=1 on a read.
- wb_ack_o  out  1  cycle termination, one-cycle pulse.
- csr_adr_o  out  17  CSR word address [17:1].
- csr_sel_o  out  2  CSR byte selects; nonzero only in the issue cycle.
- csr_we_o  out  1  CSR write; high only in the issue cycle of a write.
- csr_dat_o  out  16  CSR write data.
- csr_dat_i  in  16  CSR read data from the downstream slave.

## Operation
- The block is a four-state FSM: IDLE, ISSUE, WAIT, ACK. It also holds a 3-bit down-counter, cnt.
- IDLE: a request is wb_cyc_i & wb_stb_i. On a request:
  - At the clock edge, register csr_adr_o<=wb_adr_i, csr_sel_o<=wb_sel_i, csr_we_o<=wb_we_i, csr_dat_o<=wb_dat_i.
  - Go to ISSUE.
- ISSUE (issue cycle T):
  - The CSR outputs present the request for exactly this cycle.
  - At the edge ending ISSUE, clear csr_sel_o and csr_we_o to 0. csr_adr_o and csr_dat_o hold their values.
  - Write: go to ACK.
  - Read: go to WAIT and load cnt=READ_LAT-1.
- WAIT: each cycle, if cnt!=0 then decrement cnt. If cnt==0, capture wb_dat_o<=csr_dat_i at the edge ending this cycle and go to ACK.
- ACK:
  - wb_ack_o = wb_cyc_i & wb_stb_i. This is a combinational gate of the state register; there is no other combinational path from inputs to outputs.
  - Always return to IDLE at the next edge. A strobe held high in the ACK cycle is not taken as a new request.
- Abort: if wb_cyc_i or wb_stb_i is low in the ACK cycle, no ack is produced. The FSM still returns to IDLE.
  - A CSR write already issued is not cancelled.
  - Dropping wb_cyc_i in IDLE issues nothing.
- wb_sel_i=0 is issued as-is (csr_sel_o=0) and acked normally.
- wb_dat_o holds its last captured value until the next read capture. Writes never change it.
- Reset:
  - Effect: FSM to IDLE, cnt=0, wb_ack_o=0, wb_dat_o=0, csr_adr_o=0, csr_sel_o=0, csr_we_o=0, csr_dat_o=0.
  - Reset mid-transaction abandons it with no ack.
  - The first request is sampled at the first rising edge after sys_rst_n deasserts.

## Timing
Let R be the cycle in which a request is seen in IDLE; issue cycle T=R+1.
- Write:
  - CSR write is visible in T.
  - wb_ack_o is high in T+1 (R+2).
  - The next request can be seen at R+3, giving a minimum of 3 cycles per write.
- Read:
  - csr_dat_i is sampled at the edge ending T+READ_LAT.
  - wb_ack_o and wb_dat_o are valid in T+READ_LAT+1. With the default that is R+4.
  - The next request can be seen at R+READ_LAT+3, which is 5 cycles per read by default.
- The 2-cycle default READ_LAT matches the downstream slave: address registered at the end of T, data registered at the end of T+1, valid in T+2.
- wb_ack_o is never high for two consecutive cycles.
- csr_sel_o/csr_we_o are never nonzero outside an ISSUE cycle.

## Test plan
- Write: adr=0x00123, sel=2'b11, dat=0xBEEF, hold stb.
  - csr_we_o=1, csr_sel_o=11, csr_adr_o=0x00123, csr_dat_o=0xBEEF for exactly one cycle at R+1.
  - wb_ack_o=1 at R+2 only.
- Read with READ_LAT=2: adr=0x00040, model returns 0x1234 on csr_dat_i in T+2 only.
  - csr_we_o=0, csr_sel_o=11 at R+1.
  - wb_ack_o=1 with wb_dat_o=0x1234 at R+4.
  - A different value on csr_dat_i in T+1 or T+3 is not captured.
- Back-to-back, stb never dropped: write then read.
  - Second issue occurs at R+4, not R+3.
  - Exactly two ack pulses, non-adjacent.
- Abort: start a read, drop cyc/stb in T+1.
  - No wb_ack_o.
  - FSM returns to IDLE.
  - A new write issued afterwards completes normally.
- Reset: assert sys_rst_n=0 during WAIT.
  - All outputs go to 0 immediately (asynchronously).
  - After release, no stale ack appears.
  - A read of 0xA5A5 completes at R+4.
- Byte lanes: write with sel=2'b01 then sel=2'b00.
  - csr_sel_o=01 then 00 in the respective issue cycles.
  - Both are acked.

Source files
------------

// File: rtl/wb_csr_bridge.sv
// Wishbone-classic slave to CSR-master bridge: one CSR issue per bus cycle, fixed
// read latency, one-cycle ack. A single transaction is in flight at a time.
module wb_csr_bridge #(
  parameter int unsigned READ_LAT = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [16:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [16:0] csr_adr_o,
  output logic [1:0]  csr_sel_o,
  output logic        csr_we_o,
  output logic [15:0] csr_dat_o,
  input  logic [15:0] csr_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [15:0] wb_dat_r;
  logic [16:0] csr_adr_r;
  logic [1:0]  csr_sel_r;
  logic        csr_we_r;
  logic [15:0] csr_dat_r;
  logic        wb_req_s;

  assign wb_req_s  = wb_cyc_i & wb_stb_i;
  // Ack is the only input-to-output gate: it drops as soon as the master abandons the cycle.
  assign wb_ack_o  = (state_r == ST_ACK) & wb_req_s;
  assign wb_dat_o  = wb_dat_r;
  assign csr_adr_o = csr_adr_r;
  assign csr_sel_o = csr_sel_r;
  assign csr_we_o  = csr_we_r;
  assign csr_dat_o = csr_dat_r;

  // Transaction FSM: capture request, issue for one cycle, wait out read latency, ack.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 3'd0;
      wb_dat_r  <= 16'h0000;
      csr_adr_r <= 17'h0_0000;
      csr_sel_r <= 2'b00;
      csr_we_r  <= 1'b0;
      csr_dat_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wb_req_s) begin
            csr_adr_r <= wb_adr_i;
            csr_sel_r <= wb_sel_i;
            csr_we_r  <= wb_we_i;
            csr_dat_r <= wb_dat_i;
            state_r   <= ST_ISSUE;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          csr_sel_r <= 2'b00;
          csr_we_r  <= 1'b0;
          if (csr_we_r) begin
            state_r <= ST_ACK;
          end else begin
            cnt_r   <= CNT_LOAD;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 3'd0) begin
            cnt_r   <= cnt_r - 3'd1;
          end else begin
            wb_dat_r <= csr_dat_i;
            state_r  <= ST_ACK;
          end
        end
        ST_ACK: begin
          // A strobe still high here belongs to the finishing cycle, not a new request.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          csr_sel_r <= 2'b00;
          csr_we_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Self-checking bench for wb_csr_bridge: expected acks are queued when a request is
// driven and compared against acks captured by a negedge monitor.
module tb_wb_csr_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [16:0] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic [15:0] wb_dat_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic [16:0] csr_adr_o;
  logic [1:0]  csr_sel_o;
  logic        csr_we_o;
  logic [15:0] csr_dat_o;
  logic [15:0] csr_dat_i;

  typedef struct {
    int          at;
    logic [15:0] dat;
  } ack_t;

  ack_t        exp_q[$];
  ack_t        obs_q[$];
  int          cyc_n = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] rd_val = 16'h0000;
  logic        p1, p2;

  wb_csr_bridge #(.READ_LAT(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .csr_adr_o(csr_adr_o), .csr_sel_o(csr_sel_o), .csr_we_o(csr_we_o),
    .csr_dat_o(csr_dat_o), .csr_dat_i(csr_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  // Downstream slave model: read data valid only two cycles after the issue cycle.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p1 <= (csr_sel_o != 2'b00) && !csr_we_o;
      p2 <= p1;
    end
  end
  assign csr_dat_i = p2 ? rd_val : (16'hDEAD ^ cyc_n[15:0]);

  always @(negedge sys_clk) begin
    if (wb_ack_o === 1'b1) obs_q.push_back('{at: cyc_n, dat: wb_dat_o});
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic req(input logic [16:0] adr, input logic [1:0] sel, input logic we,
                     input logic [15:0] dat);
    wb_adr_i = adr; wb_sel_i = sel; wb_we_i = we; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    idle_bus();
    wb_adr_i = 17'h0_0000; wb_sel_i = 2'b00; wb_we_i = 1'b0; wb_dat_i = 16'h0000;
    tick();
    tick();
    n_chk++;
    if ({wb_ack_o, wb_dat_o} !== 17'h0_0000) begin
      n_fail++; $display("FAIL reset_wb: got ack=%b dat=%h, want 0/0000", wb_ack_o, wb_dat_o);
    end
    n_chk++;
    if ({csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o} !== 36'h0_0000_0000) begin
      n_fail++; $display("FAIL reset_csr: got adr=%h sel=%b we=%b dat=%h, want all 0",
                         csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_write();
    int r;
    ack_t e, o;
    tick();
    req(17'h0_0123, 2'b11, 1'b1, 16'hBEEF);
    r = cyc_n;
    exp_q.push_back('{at: r + 2, dat: last_rd});
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o, csr_adr_o, csr_dat_o} !== {1'b1, 2'b11, 17'h0_0123, 16'hBEEF}) begin
      n_fail++; $display("FAIL write_issue: got we=%b sel=%b adr=%h dat=%h, want 1/11/00123/beef",
                         csr_we_o, csr_sel_o, csr_adr_o, csr_dat_o);
    end
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o} !== 3'b000) begin
      n_fail++; $display("FAIL write_one_cycle: got we=%b sel=%b, want 0/00", csr_we_o, csr_sel_o);
    end
    tick();
    idle_bus();
    n_chk++;
    if ({csr_adr_o, csr_dat_o} !== {17'h0_0123, 16'hBEEF}) begin
      n_fail++; $display("FAIL write_hold: got adr=%h dat=%h, want 00123/beef", csr_adr_o, csr_dat_o);
    end
    tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++; $display("FAIL write_ack_count: got %0d acks, want %0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.at !== e.at || o.dat !== e.dat) begin
          n_fail++; $display("FAIL write_ack: got cyc=%0d dat=%h, want cyc=%0d dat=%h", o.at, o.dat, e.at, e.dat);
        end
      end
    end
  endtask

  task automatic test_read();
    int r;
    ack_t e, o;
    tick();
    rd_val = 16'h1234;
    req(17'h0_0040, 2'b11, 1'b0, 16'h0000);
    r = cyc_n;
    exp_q.push_back('{at: r + 4, dat: 16'h1234});
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o, csr_adr_o} !== {1'b0, 2'b11, 17'h0_0040}) begin
      n_fail++; $display("FAIL read_issue: got we=%b sel=%b adr=%h, want 0/11/00040", csr_we_o, csr_sel_o, csr_adr_o);
    end
    tick();
    n_chk++;
    if (csr_sel_o !== 2'b00) begin
      n_fail++; $display("FAIL read_one_cycle: got sel=%b, want 00", csr_sel_o);
    end
    tick();
    tick();
    tick();
    idle_bus();
    last_rd = 16'h1234;
    n_chk++;
    if (wb_dat_o !== 16'h1234) begin
      n_fail++; $display("FAIL read_hold: got dat=%h, want 1234", wb_dat_o);
    end
    tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++; $display("FAIL read_ack_count: got %0d acks, want %0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.at !== e.at || o.dat !== e.dat) begin
          n_fail++; $display("FAIL read_ack: got cyc=%0d dat=%h, want cyc=%0d dat=%h", o.at, o.dat, e.at, e.dat);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int r;
    ack_t e, o;
    tick();
    rd_val = 16'h0F0F;
    req(17'h0_0200, 2'b11, 1'b1, 16'h5555);
    r = cyc_n;
    exp_q.push_back('{at: r + 2, dat: last_rd});
    exp_q.push_back('{at: r + 7, dat: 16'h0F0F});
    tick();
    tick();
    req(17'h0_0300, 2'b11, 1'b0, 16'h0000);
    tick();
    n_chk++;
    if (csr_sel_o !== 2'b00) begin
      n_fail++; $display("FAIL b2b_no_early_issue: got sel=%b at R+3, want 00", csr_sel_o);
    end
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o, csr_adr_o} !== {1'b0, 2'b11, 17'h0_0300}) begin
      n_fail++; $display("FAIL b2b_second_issue: got we=%b sel=%b adr=%h, want 0/11/00300", csr_we_o, csr_sel_o, csr_adr_o);
    end
    tick(); tick(); tick();
    tick();
    idle_bus();
    last_rd = 16'h0F0F;
    tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_ack_count: got %0d acks, want %0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.at !== e.at || o.dat !== e.dat) begin
          n_fail++; $display("FAIL b2b_ack: got cyc=%0d dat=%h, want cyc=%0d dat=%h", o.at, o.dat, e.at, e.dat);
        end
      end
    end
  endtask

  task automatic test_abort();
    int r;
    ack_t e, o;
    tick();
    rd_val = 16'h7777;
    req(17'h0_0050, 2'b11, 1'b0, 16'h0000);
    tick();
    tick();
    idle_bus();
    // Capture still happens in WAIT even though the master has left.
    last_rd = 16'h7777;
    tick(); tick(); tick();
    req(17'h0_0070, 2'b11, 1'b1, 16'h1111);
    r = cyc_n;
    exp_q.push_back('{at: r + 2, dat: last_rd});
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o, csr_adr_o, csr_dat_o} !== {1'b1, 2'b11, 17'h0_0070, 16'h1111}) begin
      n_fail++; $display("FAIL abort_next_issue: got we=%b sel=%b adr=%h dat=%h, want 1/11/00070/1111",
                         csr_we_o, csr_sel_o, csr_adr_o, csr_dat_o);
    end
    tick();
    tick();
    idle_bus();
    tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++; $display("FAIL abort_ack_count: got %0d acks, want %0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.at !== e.at || o.dat !== e.dat) begin
          n_fail++; $display("FAIL abort_ack: got cyc=%0d dat=%h, want cyc=%0d dat=%h", o.at, o.dat, e.at, e.dat);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int r;
    ack_t e, o;
    tick();
    rd_val = 16'h9999;
    req(17'h0_0060, 2'b11, 1'b0, 16'h0000);
    tick();
    tick();
    sys_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({wb_ack_o, wb_dat_o, csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o} !== 53'h0) begin
      n_fail++; $display("FAIL reset_async: got ack=%b dat=%h adr=%h sel=%b we=%b cdat=%h, want all 0",
                         wb_ack_o, wb_dat_o, csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o);
    end
    last_rd = 16'h0000;
    idle_bus();
    tick();
    sys_rst_n = 1'b1;
    tick(); tick(); tick();
    rd_val = 16'hA5A5;
    req(17'h0_0080, 2'b11, 1'b0, 16'h0000);
    r = cyc_n;
    exp_q.push_back('{at: r + 4, dat: 16'hA5A5});
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o, csr_adr_o} !== {1'b0, 2'b11, 17'h0_0080}) begin
      n_fail++; $display("FAIL reset_read_issue: got we=%b sel=%b adr=%h, want 0/11/00080", csr_we_o, csr_sel_o, csr_adr_o);
    end
    tick(); tick(); tick();
    tick();
    idle_bus();
    last_rd = 16'hA5A5;
    tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++; $display("FAIL reset_ack_count: got %0d acks, want %0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.at !== e.at || o.dat !== e.dat) begin
          n_fail++; $display("FAIL reset_ack: got cyc=%0d dat=%h, want cyc=%0d dat=%h", o.at, o.dat, e.at, e.dat);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    int r;
    ack_t e, o;
    tick();
    req(17'h0_0010, 2'b01, 1'b1, 16'h00AB);
    r = cyc_n;
    exp_q.push_back('{at: r + 2, dat: last_rd});
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o} !== 3'b101) begin
      n_fail++; $display("FAIL lanes_sel01: got we=%b sel=%b, want 1/01", csr_we_o, csr_sel_o);
    end
    tick();
    tick();
    req(17'h0_0011, 2'b00, 1'b1, 16'hCD00);
    r = cyc_n;
    exp_q.push_back('{at: r + 2, dat: last_rd});
    tick();
    n_chk++;
    if ({csr_we_o, csr_sel_o, csr_adr_o, csr_dat_o} !== {1'b1, 2'b00, 17'h0_0011, 16'hCD00}) begin
      n_fail++; $display("FAIL lanes_sel00: got we=%b sel=%b adr=%h dat=%h, want 1/00/00011/cd00",
                         csr_we_o, csr_sel_o, csr_adr_o, csr_dat_o);
    end
    tick();
    tick();
    idle_bus();
    tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++; $display("FAIL lanes_ack_count: got %0d acks, want %0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.at !== e.at || o.dat !== e.dat) begin
          n_fail++; $display("FAIL lanes_ack: got cyc=%0d dat=%h, want cyc=%0d dat=%h", o.at, o.dat, e.at, e.dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_byte_lanes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
